serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial subtractor: computes d = a - b - bin, one bit per clock, LSB first.
//   It is the inverse companion of the combinational 4-bit full adder and shares its operand/carry port shape.
//   Used where area matters more than latency, and as a cross-check: a + b + cin fed back through this block returns a.
//   Start/busy/done handshake to the surrounding control logic.
// PARAMETERS
//   WIDTH  4  operand and result width in bits (>=2)
// PORTS
//   clk    in   1      single clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only when not busy
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow-in, captured on accepted start
//   busy   out  1      high while the operation is in progress
//   done   out  1      one-cycle pulse when d/bout are valid
//   d      out  WIDTH  difference; holds until next accepted start
//   bout   out  1      borrow-out (1 = unsigned a < b + bin)
// BEHAVIOUR
// - Reset, async: state=IDLE; busy, done, d, bout, bit counter and internal borrow all 0.
//   Reset mid-operation aborts the operation with no done pulse.
// - FSM states:
//   - IDLE:  start=1 at edge N -> load a, b shift regs; borrow<=bin; cnt<=0; go to SHIFT.
//   - SHIFT: each edge, d_i = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
//            Shift the result in at the MSB, then increment cnt.
//            At cnt==WIDTH-1 go to DONE.
//   - DONE:  single cycle; done=1; then IDLE.
// - Timing: start high at edge N -> busy=1 after N through the edge when done rises.
//   - Bits are processed at edges N+1..N+WIDTH.
//   - done=1, d/bout valid after edge N+WIDTH+1; busy=0 in that same cycle.
//   - Latency is WIDTH+1 cycles; the next start is accepted in the DONE cycle (back-to-back).
// - start while busy (SHIFT) is ignored; operands are not re-sampled.
// - Inputs a/b/bin may change freely after the accepting edge.
// - Arithmetic: modulo 2^WIDTH; bout is the final borrow.
//   - {bout,d} == ({1'b0,a} - b - bin) mod 2^(WIDTH+1).
// - cnt is $clog2(WIDTH)+1 bits wide so that it does not wrap before the terminal compare.
// CONFIGURATION
// - SERIAL_SUB_OVF_EN defined:
//   - Extra output port ovf (1 bit): two's-complement signed overflow, valid with done.
//   - ovf = (a[MSB] ^ b[MSB]) & (d[MSB] ^ a[MSB]); the bin borrow is included via d.
//   - Reset value 0; ovf holds like d.
// - Macro undefined: no ovf port, no overflow logic; all other behaviour identical.
// STRUCTURE
// - Package serial_sub_pkg: FSM state encoding localparams.
//   - ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2; ST 2'd3 is illegal and recovers to IDLE.
// - Sub-module full_subtractor (a, b, bin -> d, bout), purely combinational.
//   - One instance, driven by the LSBs of the operand shift registers.
// - Top-level holds the FSM, counter, shift registers and borrow flop.
// TESTING (WIDTH=4)
// - Reset, then a=1011 b=0100 bin=0 start:
//   - d=0111, bout=0; done exactly 5 cycles after start; busy high for 5 cycles.
// - a=1111 b=1101 bin=1 -> d=0001, bout=0.
//   - a=0000 b=0001 bin=0 -> d=1111, bout=1.
// - a=0100 b=1011 bin=0 -> d=1001, bout=1.
//   - A new start in the DONE cycle is accepted; the second result follows 5 cycles later.
// - Start a=1011 b=0100, change a/b and pulse start during SHIFT:
//   - The result is still 0111; no extra done.
// - Assert rst at cycle 2 of SHIFT:
//   - busy/done/d/bout go 0 immediately (async); no done afterwards until a new start.
// - With SERIAL_SUB_OVF_EN: 1000-0001 bin=0 -> d=0111, ovf=1.
//   - 0111-1111 -> d=1000, ovf=1.
//   - 0101-0011 -> d=0010, ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out. Purely combinational.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor {bout,d} = a - b - bin, LSB first, WIDTH+1 cycles start-to-done.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow output ovf, valid with done.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             fs_d;
  logic             fs_bout;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Operands rotate rather than shift, so after WIDTH steps they are back in
  // their original order and the MSBs are available for the overflow term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      cnt   <= '0;
      br    <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr <= {a_sr[0], a_sr[WIDTH-1:1]};
          b_sr <= {b_sr[0], b_sr[WIDTH-1:1]};
          res  <= {fs_d, res[WIDTH-1:1]};
          br   <= fs_bout;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          d     <= res;
          bout  <= br;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
`ifdef SERIAL_SUB_OVF_EN
          ovf   <= (a_sr[WIDTH-1] ^ b_sr[WIDTH-1]) & (res[WIDTH-1] ^ a_sr[WIDTH-1]);
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
